// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I execution-side types.
//   alu_op_t     : funct3 encoding of the integer ALU operations.
//   cdb_packet_t : {tag, data} pair as it travels on the common data bus.
// No ports; imported by alu_core, alu_functional_unit and the testbench.
// -----------------------------------------------------------------------------
package rv32i_pkg;

  localparam int RV_XLEN      = 32;
  localparam int RV_TAG_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD_SUB = 3'b000,
    ALU_SLL     = 3'b001,
    ALU_SLT     = 3'b010,
    ALU_SLTU    = 3'b011,
    ALU_XOR     = 3'b100,
    ALU_SRL_SRA = 3'b101,
    ALU_OR      = 3'b110,
    ALU_AND     = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic [RV_TAG_WIDTH-1:0] tag;
    logic [RV_XLEN-1:0]      data;
  } cdb_packet_t;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational RV32I integer result computation.
// Ports:
//   op     : funct3 operation select (alu_op_t)
//   alt    : funct7[5]; selects SUB for ADD_SUB and SRA for SRL_SRA only
//   a, b   : operands
//   result : XLEN-bit result; add/sub wrap modulo 2^XLEN
// -----------------------------------------------------------------------------
module alu_core
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t          op,
  input  logic             alt,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result
);

  localparam int SHW = $clog2(XLEN);

  // Only the low log2(XLEN) bits of op2 form the shift amount.
  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD_SUB: result = alt ? (a - b) : (a + b);
      ALU_SLL:     result = a << shamt;
      ALU_SLT:     result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:    result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:     result = a ^ b;
      ALU_SRL_SRA: result = alt ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
      ALU_OR:      result = a | b;
      ALU_AND:     result = a & b;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_functional_unit.sv
// -----------------------------------------------------------------------------
// alu_functional_unit
// Integer execution unit behind the ALU reservation station. Computes the
// RV32I result for each issued instruction, buffers {tag, result} in a small
// FIFO and broadcasts the FIFO head on the common data bus when granted.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   flush                 : synchronous; empties the FIFO, drops same-cycle push
//   issue_valid/ready     : issue handshake from the reservation station
//   reorder_buffer_tag_in : destination ROB tag
//   alu_op_in, alu_alt_in : funct3 and funct7[5]
//   op1_data_in, op2_data_in : operands
//   cdb_request/grant     : bus request and same-cycle arbiter grant
//   cdb_enable            : bus drive strobe (request & grant)
//   cdb_tag, cdb_data     : head entry, zero when nothing to drive
//   occupancy             : number of valid FIFO entries
//
// Handshakes: a transfer happens on a rising edge where the producer's valid
// and the consumer's ready are both 1 (issue_valid/issue_ready for issue,
// cdb_request/cdb_grant for the bus). issue_ready depends only on occupancy,
// never on issue_valid or cdb_grant, so a full FIFO does not accept an issue
// even if the head is popped in the same cycle.
//
// Optional feature (macro ALU_FU_BYPASS_EN): with an empty FIFO the live ALU
// result is offered on the bus in the issue cycle; if granted it is broadcast
// and never enters the FIFO. Without the macro the minimum latency is 1 cycle.
// -----------------------------------------------------------------------------
module alu_functional_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [TAG_WIDTH-1:0]       reorder_buffer_tag_in,
  input  logic [2:0]                 alu_op_in,
  input  logic                       alu_alt_in,
  input  logic [XLEN-1:0]            op1_data_in,
  input  logic [XLEN-1:0]            op2_data_in,
  output logic                       cdb_request,
  input  logic                       cdb_grant,
  output logic                       cdb_enable,
  output logic [TAG_WIDTH-1:0]       cdb_tag,
  output logic [XLEN-1:0]            cdb_data,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] alu_result;

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .op     (alu_op_t'(alu_op_in)),
    .alt    (alu_alt_in),
    .a      (op1_data_in),
    .b      (op2_data_in),
    .result (alu_result)
  );

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [TAG_WIDTH-1:0] tag_mem_q  [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem_d  [DEPTH];
  logic [XLEN-1:0]      data_mem_q [DEPTH];
  logic [XLEN-1:0]      data_mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q,  count_d;

  logic empty;
  logic full;
  logic bypass_req;
  logic push;
  logic pop;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign issue_ready = ~full;
  assign occupancy   = count_q;

`ifdef ALU_FU_BYPASS_EN
  assign bypass_req = empty & issue_valid & ~flush;
`else
  assign bypass_req = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // CDB side: the buffered head always wins over the bypass path, which keeps
  // results in issue order.
  // ---------------------------------------------------------------------------
  always_comb begin
    cdb_request = ~empty | bypass_req;
    cdb_tag     = '0;
    cdb_data    = '0;
    if (!empty) begin
      cdb_tag  = tag_mem_q[rd_ptr_q];
      cdb_data = data_mem_q[rd_ptr_q];
    end else if (bypass_req) begin
      cdb_tag  = reorder_buffer_tag_in;
      cdb_data = alu_result;
    end
    cdb_enable = cdb_request & cdb_grant;
  end

  // A granted bypass consumes the issue directly, so it must not also be pushed.
  assign push = issue_valid & issue_ready & ~(bypass_req & cdb_grant);
  assign pop  = cdb_enable & ~empty;

  // ---------------------------------------------------------------------------
  // Next-state logic. Pointers wrap naturally because DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_mem_d  = tag_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      // The broadcast seen this cycle still stands; only buffered state is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        tag_mem_d[wr_ptr_q]  = reorder_buffer_tag_in;
        data_mem_d[wr_ptr_q] = alu_result;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tag_mem_q  <= tag_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_functional_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_functional_unit
// Self-checking bench for alu_functional_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_alu_functional_unit;
  import rv32i_pkg::*;

  localparam int XLEN  = 32;
  localparam int TW    = 32;
  localparam int DEPTH = 2;

`ifdef ALU_FU_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [TW-1:0]         tag_in;
  logic [2:0]            alu_op_in;
  logic                  alu_alt_in;
  logic [XLEN-1:0]       op1, op2;
  logic                  cdb_request;
  logic                  cdb_grant;
  logic                  cdb_enable;
  logic [TW-1:0]         cdb_tag;
  logic [XLEN-1:0]       cdb_data;
  logic [$clog2(DEPTH):0] occupancy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_functional_unit #(.XLEN(XLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .flush                 (flush),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .reorder_buffer_tag_in (tag_in),
    .alu_op_in             (alu_op_in),
    .alu_alt_in            (alu_alt_in),
    .op1_data_in           (op1),
    .op2_data_in           (op2),
    .cdb_request           (cdb_request),
    .cdb_grant             (cdb_grant),
    .cdb_enable            (cdb_enable),
    .cdb_tag               (cdb_tag),
    .cdb_data              (cdb_data),
    .occupancy             (occupancy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks;
  int n_pass;

  logic [63:0] exp_q[$];              // {tag, data} of results waiting for the bus
  logic [31:0] bcast_tags[$];         // every tag seen with cdb_enable=1
  logic [31:0] bcast_data[logic [31:0]];
  logic [31:0] obs_occ;
  logic        obs_ready;
  logic        obs_req;
  logic        obs_en;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference ALU from the RV32I rules, written with plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    int          sa;
    int          sb;
    sh = b % 32;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'(sa >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [31:0] t, input logic [2:0] op,
                       input logic alt, input logic [31:0] a, input logic [31:0] b,
                       input logic g, input logic f);
    issue_valid = v;
    tag_in      = t;
    alu_op_in   = op;
    alu_alt_in  = alt;
    op1         = a;
    op2         = b;
    cdb_grant   = g;
    flush       = f;
  endtask

  task automatic idle(input logic g);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, g, 1'b0);
  endtask

  // One clock: compare outputs at the falling edge against the model, then
  // advance the model across the rising edge. Inputs are driven at posedge+1.
  task automatic cycle();
    cdb_packet_t head;
    logic [31:0] res;
    logic        byp_req;
    logic        exp_req;
    logic        exp_en;
    logic        exp_ready;
    @(negedge clk);
    res       = ref_alu(alu_op_in, alu_alt_in, op1, op2);
    byp_req   = BYPASS && exp_q.size() == 0 && issue_valid && !flush;
    head      = '0;
    if (exp_q.size() != 0) head = exp_q[0];
    else if (byp_req)      head = {tag_in, res};
    exp_req   = (exp_q.size() != 0) || byp_req;
    exp_en    = exp_req && cdb_grant;
    exp_ready = exp_q.size() < DEPTH;
    check("occupancy",   64'(occupancy),   64'(exp_q.size()));
    check("issue_ready", 64'(issue_ready), 64'(exp_ready));
    check("cdb_request", 64'(cdb_request), 64'(exp_req));
    check("cdb_enable",  64'(cdb_enable),  64'(exp_en));
    check("cdb_tag",     64'(cdb_tag),     64'(head.tag));
    check("cdb_data",    64'(cdb_data),    64'(head.data));
    obs_occ   = 32'(occupancy);
    obs_ready = issue_ready;
    obs_req   = cdb_request;
    obs_en    = cdb_enable;
    if (cdb_enable) begin
      bcast_tags.push_back(cdb_tag);
      bcast_data[cdb_tag] = cdb_data;
    end
    if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_en && exp_q.size() != 0) void'(exp_q.pop_front());
      if (issue_valid && exp_ready && !(byp_req && cdb_grant))
        exp_q.push_back({tag_in, res});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op_case(input string name, input logic [31:0] t, input logic [2:0] op,
                         input logic alt, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expd);
    drive(1'b1, t, op, alt, a, b, 1'b1, 1'b0);
    cycle();
    idle(1'b1);
    cycle();
    cycle();
    check(name, 64'(bcast_data[t]), 64'(expd));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    logic seen;
    n_checks = 0;
    n_pass   = 0;
    idle(1'b1);
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_occupancy", 64'(occupancy),   64'd0);
    check("rst_request",   64'(cdb_request), 64'd0);
    check("rst_enable",    64'(cdb_enable),  64'd0);
    check("rst_tag",       64'(cdb_tag),     64'd0);
    check("rst_data",      64'(cdb_data),    64'd0);
    #9 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_issue_ready", 64'(issue_ready), 64'd1);

    // Single ADD, grant held high.
    drive(1'b1, 32'd5, 3'd0, 1'b0, 32'd7, 32'd9, 1'b1, 1'b0);
    cycle();
    check("add_issue_cycle_en", 64'(obs_en), 64'(BYPASS));
    idle(1'b1);
    cycle();
    check("add_occ_after_issue", 64'(obs_occ), BYPASS ? 64'd0 : 64'd1);
    check("add_en_next_cycle", 64'(obs_en), BYPASS ? 64'd0 : 64'd1);
    cycle();
    check("add_occ_drained", 64'(obs_occ), 64'd0);
    check("add_result", 64'(bcast_data[32'd5]), 64'd16);

    // Operation coverage.
    op_case("sub",      32'd10, 3'd0, 1'b1, 32'd3,          32'd5,          32'hFFFF_FFFE);
    op_case("sra",      32'd11, 3'd5, 1'b1, 32'h8000_0000,  32'd4,          32'hF800_0000);
    op_case("slt",      32'd12, 3'd2, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1);
    op_case("sltu",     32'd13, 3'd3, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0);
    op_case("sll33",    32'd14, 3'd1, 1'b0, 32'h4000_0001,  32'd33,         32'h8000_0002);
    op_case("xor_alt",  32'd15, 3'd4, 1'b1, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FF00);
    op_case("srl",      32'd16, 3'd5, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000);
    op_case("and_alt",  32'd17, 3'd7, 1'b1, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234);

    // Backpressure: tags 1,2,3 with grant low.
    drive(1'b1, 32'd1, 3'd0, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'd2, 3'd0, 1'b0, 32'd2, 32'd2, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'd3, 3'd0, 1'b0, 32'd3, 32'd3, 1'b0, 1'b0);
    base = bcast_tags.size();
    cycle();
    check("bp_ready_full", 64'(obs_ready), 64'd0);
    check("bp_occ_full",   64'(obs_occ),   64'd2);
    idle(1'b1);
    cycle();
    cycle();
    cycle();
    check("bp_count", 64'(bcast_tags.size() - base), 64'd2);
    check("bp_first", 64'(bcast_tags[base]),     64'd1);
    check("bp_second", 64'(bcast_tags[base + 1]), 64'd2);

    // Simultaneous push and pop at occupancy 1, long enough to wrap pointers.
    drive(1'b1, 32'd20, 3'd0, 1'b0, 32'd20, 32'd0, 1'b0, 1'b0);
    cycle();
    base = bcast_tags.size();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(21 + i), 3'd0, 1'b0, 32'(i), 32'd100, 1'b1, 1'b0);
      cycle();
      check("pp_occ_steady", 64'(obs_occ), 64'd1);
    end
    idle(1'b1);
    cycle();
    cycle();
    check("pp_count", 64'(bcast_tags.size() - base), 64'd7);
    for (int i = 0; i < 7; i++)
      check("pp_order", 64'(bcast_tags[base + i]), 64'(20 + i));

    // Flush at occupancy 2 with a concurrent issue.
    drive(1'b1, 32'd30, 3'd0, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'd31, 3'd0, 1'b0, 32'd3, 32'd4, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'd99, 3'd0, 1'b0, 32'd5, 32'd6, 1'b0, 1'b1);
    cycle();
    idle(1'b0);
    cycle();
    check("flush_occ", 64'(obs_occ), 64'd0);
    check("flush_req", 64'(obs_req), 64'd0);
    idle(1'b1);
    cycle();
    cycle();
    seen = 1'b0;
    foreach (bcast_tags[i]) if (bcast_tags[i] == 32'd99) seen = 1'b1;
    check("flush_tag_absent", 64'(seen), 64'd0);

    // Asynchronous reset between edges with results buffered.
    drive(1'b1, 32'd40, 3'd0, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'd41, 3'd0, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
    cycle();
    idle(1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_occupancy", 64'(occupancy),   64'd0);
    check("arst_request",   64'(cdb_request), 64'd0);
    check("arst_enable",    64'(cdb_enable),  64'd0);
    check("arst_tag",       64'(cdb_tag),     64'd0);
    check("arst_data",      64'(cdb_data),    64'd0);
    exp_q.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_issue_ready", 64'(issue_ready), 64'd1);
    cycle();

`ifdef ALU_FU_BYPASS_EN
    // Zero-latency bypass from an empty FIFO.
    idle(1'b1);
    cycle();
    drive(1'b1, 32'd50, 3'd0, 1'b0, 32'd100, 32'd23, 1'b1, 1'b0);
    cycle();
    check("byp_enable", 64'(obs_en), 64'd1);
    idle(1'b1);
    cycle();
    check("byp_occ", 64'(obs_occ), 64'd0);
    check("byp_data", 64'(bcast_data[32'd50]), 64'd123);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      cycle();
    end
    idle(1'b1);
    for (int n = 0; n < 4; n++) cycle();
    check("final_drained", 64'(exp_q.size()), 64'(occupancy));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_functional_unit.md
Name: alu_functional_unit

Overview:
- Integer execution unit directly downstream of the ALU reservation station in the Tomasulo core.
- Accepts one dispatched instruction per cycle: ROB tag, ALU op, and two resolved operands.
- Computes the RV32I integer result and holds completed results in a small FIFO.
- Requests the common data bus (CDB) and drives tag/data onto it when granted by the CDB arbiter.

Parameters:
- XLEN, 32, datapath width.
- TAG_WIDTH, 32, ROB tag width.
- DEPTH, 2, result FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all buffered results and any same-cycle issue.
- issue_valid  input  1  reservation station presents a ready instruction.
- issue_ready  output  1  unit can accept this cycle.
- reorder_buffer_tag_in  input  TAG_WIDTH  destination ROB tag.
- alu_op_in  input  3  RV32I funct3 encoding.
- alu_alt_in  input  1  funct7[5]; selects SUB (op 000) or SRA (op 101).
- op1_data_in  input  XLEN  operand 1.
- op2_data_in  input  XLEN  operand 2.
- cdb_request  output  1  head result waiting for the bus.
- cdb_grant  input  1  arbiter grant, same cycle as request.
- cdb_enable  output  1  bus drive strobe; equals cdb_request AND cdb_grant.
- cdb_tag  output  TAG_WIDTH  head ROB tag.
- cdb_data  output  XLEN  head result.
- occupancy  output  $clog2(DEPTH)+1  number of valid FIFO entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count cleared; occupancy=0.
  - cdb_request=0, cdb_enable=0, cdb_tag=0, cdb_data=0.
  - issue_ready=1 once reset deasserts.
- ALU, combinational over the inputs:
  - 000: ADD, or SUB if alt. 001: SLL. 010: SLT (signed). 011: SLTU. 100: XOR. 101: SRL, or SRA if alt. 110: OR. 111: AND.
  - Shift amount is op2[$clog2(XLEN)-1:0].
  - Add/sub wrap modulo 2^XLEN.
  - alu_alt_in is ignored for ops other than 000 and 101.
- Issue handshake:
  - Push occurs when issue_valid AND issue_ready at the clock edge.
  - Computed {tag, result} is written at the tail.
  - issue_ready = (occupancy < DEPTH); there is no same-cycle pop credit.
- Latency: a result is written at edge N and presents on cdb_* during cycle N+1 at the earliest.
- CDB side:
  - cdb_request = (occupancy != 0).
  - cdb_tag and cdb_data show the FIFO head while non-empty and are zero when empty.
  - Pop occurs when cdb_enable=1 at the edge.
  - Head is held stable while request=1 and grant=0.
- Simultaneous push and pop (not full): both occur; occupancy unchanged; order preserved.
- Full (occupancy=DEPTH):
  - issue_ready=0; an asserted issue_valid is ignored.
  - A pop in that cycle drops occupancy to DEPTH-1; issue_ready rises the next cycle.
- Empty: a grant with no request has no effect; cdb_enable stays 0.
- Pointer wrap: read and write pointers wrap modulo DEPTH; results leave in strict FIFO order.
- flush=1:
  - At the edge, occupancy becomes 0 and pointers reset.
  - A same-cycle push and pop are discarded.
  - cdb_enable may still be 1 during the flush cycle; that broadcast is valid.
  - flush takes priority over push.
- Reset mid-operation: all buffered results are lost; no CDB broadcast in the reset cycle.

Optional Feature:
- Macro: ALU_FU_BYPASS_EN.
- Defined: when the FIFO is empty and issue_valid=1:
  - cdb_request is asserted combinationally in the issue cycle, with cdb_tag/cdb_data taken from the live ALU output.
  - If cdb_grant=1, the result is broadcast that cycle and not written into the FIFO (zero-cycle latency).
  - If cdb_grant=0, it is pushed normally.
  - flush blocks the bypass.
- Undefined: no bypass; minimum latency is one cycle as above.

Decomposition:
- Shared package rv32i_pkg:
  - alu_op_t enum (3-bit funct3 values: ALU_ADD_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL_SRA, ALU_OR, ALU_AND).
  - cdb_packet_t struct {tag, data}.
- Sub-module alu_core: purely combinational result computation.
- FIFO and handshake logic live in alu_functional_unit.

Test Plan:
- Reset then single issue: ADD tag=5, 7+9, grant held 1.
  - Response: cdb_enable=1 next cycle with tag=5, data=16.
  - occupancy goes 1 then 0.
- Op coverage (grant=1):
  - SUB 3-5 -> 0xFFFFFFFE.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLT -1<1 -> 1.
  - SLTU 0xFFFFFFFF<1 -> 0.
  - SLL by 33 -> shift by 1.
- Backpressure, grant=0, issue tags 1,2,3 in consecutive cycles:
  - Tags 1 and 2 accepted; issue_ready=0 for tag 3 and occupancy=2.
  - Raising grant broadcasts tag 1 then tag 2.
- Simultaneous push and pop at occupancy=1 with grant=1: occupancy stays 1 and order is preserved across more than 2·DEPTH operations (pointer wrap).
- flush at occupancy=2 with a concurrent issue: next cycle occupancy=0, cdb_request=0, and the issued tag never appears on the CDB.
- Asynchronous reset mid-stream (reset low between edges): outputs zero immediately, issue_ready=1 after release.
- With ALU_FU_BYPASS_EN, empty FIFO, issue plus grant in the same cycle: cdb_enable=1 in that cycle and occupancy stays 0.
